pvt_measure_sequencer: RTL and testbench
========================================

# pvt_measure_sequencer

Sequences measurement runs across `NUM_MON` delay-chain monitor instances sharing one result path. Issues a one-cycle start to the selected monitor, opens a fixed gate window, and takes the modular difference of the monitor's event count across that window. It averages `2**AVG_LOG2` samples per monitor and hands the result to the readout logic over a valid/ready handshake. Sits between the monitor array and the register/readout block of the PVT monitor suite.

## Interface
- `NUM_MON`, 4: number of monitor instances; must be ≥ 1.
- `CNT_WIDTH`, 8: width of each monitor count and of the result.
- `GATE_CYCLES`, 200: gate window length in `clk` cycles; must be ≥ 2.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per monitor.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `enable`  in  1  continuous round-robin scanning while high.
- `trig`  in  1  one-cycle request for a single scan of all monitors; acted on only when idle with `enable` low.
- `mon_start`  out  `NUM_MON`  one-hot start pulse to the selected monitor.
- `mon_cnt`  in  `NUM_MON*CNT_WIDTH`  packed free-running monitor counts; monitor k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  `CNT_WIDTH`  averaged delta.
- `res_id`  out  `$clog2(NUM_MON)` (min 1)  monitor index of `res_data`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, START, GATE, CAPTURE and OUTPUT.
- **IDLE**
  - Leaves on `enable` or on a `trig` qualified by `enable` low.
  - Sets `sel` = 0 and clears `acc` and `nsamp`.
  - Goes to START.
- **START**
  - Asserts `mon_start[sel]` for exactly one cycle.
  - Goes to GATE.
- **GATE**
  - On the first GATE cycle, latches `base` = `mon_cnt[sel]`.
  - Counts `GATE_CYCLES` cycles, then goes to CAPTURE.
- **CAPTURE**
  - Computes `delta` = (`mon_cnt[sel]` − `base`) mod 2^`CNT_WIDTH`, so counter wrap is absorbed.
  - Adds `delta` to `acc`, which is `CNT_WIDTH+AVG_LOG2` bits wide and cannot overflow.
  - Increments `nsamp`.
  - If `nsamp` reaches 2^`AVG_LOG2`, goes to OUTPUT. Otherwise goes back to START.
- **OUTPUT**
  - Drives `res_valid` = 1, `res_data` = `acc >> AVG_LOG2` (truncating) and `res_id` = `sel`.
  - Holds all three stable until `res_ready`.
  - On handshake: clears `acc` and `nsamp`, and sets `sel` = (`sel`+1) mod `NUM_MON`.
  - In continuous mode, goes to START if `enable` is still high. Otherwise goes to IDLE.
  - In single-scan mode, goes to START for the next monitor. After the handshake for the last monitor, goes to IDLE.
- **Dropping `enable` mid-scan:** the current monitor's batch completes and is delivered, then the FSM returns to IDLE.
- **`trig` outside IDLE, or with `enable` high:** ignored, with no queuing.
- **Backpressure:** no `mon_start` is issued while in OUTPUT.
- **Reset mid-operation:** returns to IDLE immediately; any partial batch is discarded.

## Timing
- **Reset values:**
  - `mon_start` = 0, `res_valid` = 0, `res_data` = 0, `res_id` = 0, `busy` = 0.
  - FSM in IDLE, `sel` = 0, `acc` = 0.
- All outputs are registered.
- `mon_start` is high during the cycle the FSM is in START.
- **Per-sample cost:** `GATE_CYCLES` + 2 cycles (START + gate + CAPTURE).
- **Per-result latency, from leaving IDLE to the first `res_valid`:** 2^`AVG_LOG2` × (`GATE_CYCLES`+2) cycles.
- **Handshake:**
  - Transfer occurs on a cycle with `res_valid` && `res_ready`.
  - `res_valid` drops in the next cycle; a new result is never back-to-back.
  - `res_ready` asserted before `res_valid` has no effect.
- **`busy`:** rises the cycle after the qualifying `enable`/`trig`, and falls on entry to IDLE.

## Configuration
- Macro `PVT_SEQ_MINMAX_EN`.
- **Defined:**
  - Adds outputs `res_min` and `res_max` (`CNT_WIDTH` each): the minimum and maximum `delta` within the batch.
  - Both are updated in CAPTURE, seeded by the first sample, presented with `res_data`, and reset to 0.
- **Undefined:**
  - The ports and their logic are absent.
  - All other behaviour is identical.

## Structure
- **Package `pvt_seq_pkg`:**
  - State enum `pvt_seq_state_e` (IDLE, START, GATE, CAPTURE, OUTPUT).
  - Helper function for the `res_id` width.
  - Function `cnt_delta` for modular subtraction.
- **Sub-module `pvt_seq_accum`:**
  - Holds the accumulator, sample counter, averaging shift, and the optional min/max.
  - Controls: clear, add-enable, `delta` input.
  - Outputs: done flag, `res_data`, min, max.
- **Top level:** holds the FSM, gate counter, selection mux and handshake.

## Test plan
- **Single scan:** `NUM_MON`=4, `AVG_LOG2`=2, `GATE_CYCLES`=200, `res_ready`=1, monitors increment 1 per cycle, one `trig` pulse → 4 results with `res_id` 0,1,2,3 in order, each `res_data`=200, then `busy`=0.
- **Wrap-around:** `base`=250, count advances 10 per sample → `delta`=10 with no corruption; `res_data`=10.
- **Backpressure:** hold `res_ready`=0 for 50 cycles → `res_valid`, `res_data` and `res_id` stay stable and `mon_start` stays 0; release → one transfer, then `mon_start` for the next `sel`.
- **Continuous mode:** keep `enable` high across 6 results → `res_id` sequence 0,1,2,3,0,1; drop `enable` during the sample for `res_id` 2 → the batch for 2 is delivered, then IDLE.
- **Reset mid-GATE:** assert `rst` for one cycle → all outputs at reset values the next cycle; a new `trig` restarts at `res_id` 0.
- **Min/max (`PVT_SEQ_MINMAX_EN` defined):** deltas 5,9,3,7 → `res_min`=3, `res_max`=9, `res_data`=6.

Source files
------------

// File: rtl/pvt_seq_pkg.sv
// Shared types and helpers for the PVT measurement sequencer.
package pvt_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    GATE    = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4
  } pvt_seq_state_e;

  localparam int MAX_CNT_W = 64;

  function automatic int id_width(input int num_mon);
    return (num_mon > 1) ? $clog2(num_mon) : 1;
  endfunction

  // Difference modulo 2**width, so a counter that wrapped inside the window still gives the true delta.
  function automatic logic [MAX_CNT_W-1:0] cnt_delta(input logic [MAX_CNT_W-1:0] cur,
                                                     input logic [MAX_CNT_W-1:0] base,
                                                     input int width);
    logic [MAX_CNT_W-1:0] mask;
    mask = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
    return (cur - base) & mask;
  endfunction

endpackage

// File: rtl/pvt_seq_accum.sv
// Per-monitor sample accumulator with averaging; min/max tracking when PVT_SEQ_MINMAX_EN is defined.
module pvt_seq_accum
  import pvt_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 add,
  input  logic [CNT_WIDTH-1:0] delta,
  output logic                 done,
`ifdef PVT_SEQ_MINMAX_EN
  output logic [CNT_WIDTH-1:0] res_min,
  output logic [CNT_WIDTH-1:0] res_max,
`endif
  output logic [CNT_WIDTH-1:0] res_data
);

  localparam int ACC_W = CNT_WIDTH + AVG_LOG2;
  localparam int NS_W  = AVG_LOG2 + 1;
  localparam logic [NS_W-1:0] LAST_SAMPLE = NS_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]     acc_reg;
  logic [ACC_W-1:0]     acc_sum;
  logic [NS_W-1:0]      nsamp_reg;
  logic [CNT_WIDTH-1:0] res_data_reg;

  assign acc_sum  = acc_reg + ACC_W'(delta);
  // The final sample's delta is folded in directly so the result is ready on entry to OUTPUT.
  assign done     = add && (nsamp_reg == LAST_SAMPLE);
  assign res_data = res_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      nsamp_reg    <= '0;
      res_data_reg <= '0;
    end else if (clear) begin
      acc_reg      <= '0;
      nsamp_reg    <= '0;
    end else if (add) begin
      acc_reg   <= acc_sum;
      nsamp_reg <= nsamp_reg + NS_W'(1);
      if (done) res_data_reg <= CNT_WIDTH'(acc_sum >> AVG_LOG2);
    end
  end

`ifdef PVT_SEQ_MINMAX_EN
  logic [CNT_WIDTH-1:0] min_reg, max_reg, min_new, max_new;
  logic [CNT_WIDTH-1:0] res_min_reg, res_max_reg;
  logic                 first;

  assign first   = (nsamp_reg == '0);
  assign min_new = (first || delta < min_reg) ? delta : min_reg;
  assign max_new = (first || delta > max_reg) ? delta : max_reg;
  assign res_min = res_min_reg;
  assign res_max = res_max_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_reg     <= '0;
      max_reg     <= '0;
      res_min_reg <= '0;
      res_max_reg <= '0;
    end else if (add) begin
      min_reg <= min_new;
      max_reg <= max_new;
      if (done) begin
        res_min_reg <= min_new;
        res_max_reg <= max_new;
      end
    end
  end
`endif

endmodule

// File: rtl/pvt_measure_sequencer.sv
// Round-robin / single-scan measurement sequencer for shared delay-chain monitors.
// Optional min/max outputs are enabled by defining PVT_SEQ_MINMAX_EN.
module pvt_measure_sequencer
  import pvt_seq_pkg::*;
#(
  parameter int NUM_MON     = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int GATE_CYCLES = 200,
  parameter int AVG_LOG2    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          trig,
  output logic [NUM_MON-1:0]            mon_start,
  input  logic [NUM_MON*CNT_WIDTH-1:0]  mon_cnt,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [CNT_WIDTH-1:0]          res_data,
  output logic [id_width(NUM_MON)-1:0]  res_id,
`ifdef PVT_SEQ_MINMAX_EN
  output logic [CNT_WIDTH-1:0]          res_min,
  output logic [CNT_WIDTH-1:0]          res_max,
`endif
  output logic                          busy
);

  localparam int ID_W = id_width(NUM_MON);
  localparam int GC_W = $clog2(GATE_CYCLES);
  localparam logic [ID_W-1:0] LAST_SEL  = ID_W'(NUM_MON - 1);
  localparam logic [GC_W-1:0] LAST_GATE = GC_W'(GATE_CYCLES - 1);

  pvt_seq_state_e       state_reg, state_next;
  logic [ID_W-1:0]      sel_reg, sel_next;
  logic                 single_reg, single_next;
  logic [GC_W-1:0]      gate_cnt_reg;
  logic [CNT_WIDTH-1:0] base_reg, cur_cnt, delta;
  logic                 acc_clear, acc_add, acc_done;
  logic [NUM_MON-1:0]   mon_start_reg;
  logic                 res_valid_reg, busy_reg;
  logic [ID_W-1:0]      res_id_reg;
  logic [CNT_WIDTH-1:0] cnt_arr [NUM_MON];

  generate
    for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_cnt
      assign cnt_arr[gi] = mon_cnt[gi*CNT_WIDTH +: CNT_WIDTH];
    end
  endgenerate

  assign cur_cnt = cnt_arr[sel_reg];
  assign delta   = CNT_WIDTH'(cnt_delta(MAX_CNT_W'(cur_cnt), MAX_CNT_W'(base_reg), CNT_WIDTH));

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    single_next = single_reg;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    case (state_reg)
      IDLE: begin
        sel_next  = '0;
        acc_clear = 1'b1;
        if (enable) begin
          state_next  = START;
          single_next = 1'b0;
        end else if (trig) begin
          state_next  = START;
          single_next = 1'b1;
        end
      end
      START:   state_next = GATE;
      GATE:    if (gate_cnt_reg == LAST_GATE) state_next = CAPTURE;
      CAPTURE: begin
        acc_add    = 1'b1;
        state_next = acc_done ? OUTPUT : START;
      end
      OUTPUT: begin
        if (res_ready) begin
          acc_clear = 1'b1;
          sel_next  = (sel_reg == LAST_SEL) ? '0 : sel_reg + ID_W'(1);
          if (single_reg) state_next = (sel_reg == LAST_SEL) ? IDLE : START;
          else            state_next = enable ? START : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output registers are loaded from next-state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      single_reg    <= 1'b0;
      gate_cnt_reg  <= '0;
      base_reg      <= '0;
      mon_start_reg <= '0;
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      single_reg   <= single_next;
      gate_cnt_reg <= (state_reg == GATE) ? gate_cnt_reg + GC_W'(1) : '0;
      if (state_reg == GATE && gate_cnt_reg == '0) base_reg <= cur_cnt;
      mon_start_reg <= (state_next == START) ? (NUM_MON'(1) << sel_next) : '0;
      res_valid_reg <= (state_next == OUTPUT);
      if (acc_done) res_id_reg <= sel_reg;
      busy_reg      <= (state_next != IDLE);
    end
  end

  pvt_seq_accum #(
    .CNT_WIDTH (CNT_WIDTH),
    .AVG_LOG2  (AVG_LOG2)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .add      (acc_add),
    .delta    (delta),
    .done     (acc_done),
`ifdef PVT_SEQ_MINMAX_EN
    .res_min  (res_min),
    .res_max  (res_max),
`endif
    .res_data (res_data)
  );

  assign mon_start = mon_start_reg;
  assign res_valid = res_valid_reg;
  assign res_id    = res_id_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_pvt_measure_sequencer.sv
// Directed bench for pvt_measure_sequencer (default parameters); min/max step runs when PVT_SEQ_MINMAX_EN is defined.
module tb_pvt_measure_sequencer;

  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic        res_ready = 1'b0;
  logic [3:0]  mon_start;
  logic [31:0] mon_cnt;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        busy;
`ifdef PVT_SEQ_MINMAX_EN
  logic [7:0]  res_min, res_max;
`endif

  logic [7:0]  cnt [4];
  logic [7:0]  load_val [4];
  logic        load_req = 1'b0;
  int          mode = 0;
  int          tick = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pvt_measure_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .trig      (trig),
    .mon_start (mon_start),
    .mon_cnt   (mon_cnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
`ifdef PVT_SEQ_MINMAX_EN
    .res_min   (res_min),
    .res_max   (res_max),
`endif
    .busy      (busy)
  );

  assign mon_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};

  // Monitor model: mode 0 +1/cycle, mode 1 +1 every 20 cycles, mode 2 +(k+1)/cycle, mode 3 held.
  always @(posedge clk) begin
    tick <= tick + 1;
    for (int k = 0; k < 4; k++) begin
      if (load_req) cnt[k] <= load_val[k];
      else begin
        case (mode)
          0: cnt[k] <= cnt[k] + 8'd1;
          1: if (tick % 20 == 0) cnt[k] <= cnt[k] + 8'd1;
          2: cnt[k] <= cnt[k] + 8'(k + 1);
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < LIMIT), 32'd1);
  endtask

  task automatic load_all(input logic [7:0] v);
    @(negedge clk);
    for (int k = 0; k < 4; k++) load_val[k] = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mon_start"}, 32'(mon_start), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_res_id"},    32'(res_id),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] d0;
    logic [1:0] i0;
    logic stable, no_start;
    logic [7:0] exp_data [4];
`ifdef PVT_SEQ_MINMAX_EN
    logic [7:0] mm_delta [4];
`endif
    exp_data[0] = 8'd200; exp_data[1] = 8'd144; exp_data[2] = 8'd88; exp_data[3] = 8'd32;

    load_all(8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single scan, always-ready consumer
    mode = 0;
    res_ready = 1'b1;
    pulse_trig();
    check("ss_busy_rise", 32'(busy), 32'd1);
    check("ss_start0", 32'(mon_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("ss_wait", n);
      if (i == 0) check("ss_latency", 32'(n), 32'd808);
      check("ss_res_id", 32'(res_id), 32'(i));
      check("ss_res_data", 32'(res_data), 32'd200);
      $display("ss result: id=%0d data=%0d", res_id, res_data);
      @(negedge clk);
      check("ss_valid_drop", 32'(res_valid), 32'd0);
      if (i < 3) check("ss_next_start", 32'(mon_start), 32'(4'b0001 << (i + 1)));
      else       check("ss_busy_fall", 32'(busy), 32'd0);
    end

    // Backpressure, then reset in the middle of the next gate window
    res_ready = 1'b0;
    pulse_trig();
    wait_valid("bp_wait", n);
    d0 = res_data;
    i0 = res_id;
    check("bp_res_data", 32'(d0), 32'd200);
    check("bp_res_id", 32'(i0), 32'd0);
    stable = 1'b1;
    no_start = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 || res_id !== i0) stable = 1'b0;
      if (mon_start !== 4'b0000) no_start = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_no_start", 32'(no_start), 32'd1);
    $display("bp result: id=%0d data=%0d held 50 cycles", i0, d0);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 32'(res_valid), 32'd0);
    check("bp_next_start", 32'(mon_start), 32'd2);
    repeat (10) @(negedge clk);
    do_reset();
    check_reset_outputs("midgate_rst");

    // Counter wrap: 245 upward, +10 per gate window
    mode = 1;
    load_all(8'd245);
    pulse_trig();
    wait_valid("wrap_wait", n);
    check("wrap_res_id", 32'(res_id), 32'd0);
    check("wrap_res_data", 32'(res_data), 32'd10);
    $display("wrap result: id=%0d data=%0d", res_id, res_data);
    do_reset();
    check("wrap_rst_busy", 32'(busy), 32'd0);

    // Continuous scanning; enable dropped while monitor 2 is sampling
    mode = 2;
    enable = 1'b1;
    for (int r = 0; r < 7; r++) begin
      wait_valid("cont_wait", n);
      check("cont_res_id", 32'(res_id), 32'(r % 4));
      check("cont_res_data", 32'(res_data), 32'(exp_data[r % 4]));
      $display("cont result %0d: id=%0d data=%0d", r, res_id, res_data);
      @(negedge clk);
      check("cont_valid_drop", 32'(res_valid), 32'd0);
      if (r == 5) enable = 1'b0;
      if (r == 6) check("cont_busy_fall", 32'(busy), 32'd0);
    end
    repeat (5) @(negedge clk);
    check("cont_stay_idle", 32'(busy), 32'd0);
    check("cont_no_start", 32'(mon_start), 32'd0);

`ifdef PVT_SEQ_MINMAX_EN
    // Deltas 5,9,3,7 injected mid-gate on monitor 0
    mm_delta[0] = 8'd5; mm_delta[1] = 8'd9; mm_delta[2] = 8'd3; mm_delta[3] = 8'd7;
    mode = 3;
    res_ready = 1'b1;
    pulse_trig();
    for (int s = 0; s < 4; s++) begin
      n = 0;
      while (mon_start[0] !== 1'b1 && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      check("mm_start_timeout", 32'(n < LIMIT), 32'd1);
      repeat (5) @(negedge clk);
      for (int k = 0; k < 4; k++) load_val[k] = cnt[k];
      load_val[0] = cnt[0] + mm_delta[s];
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
    end
    wait_valid("mm_wait", n);
    check("mm_res_id", 32'(res_id), 32'd0);
    check("mm_res_data", 32'(res_data), 32'd6);
    check("mm_res_min", 32'(res_min), 32'd3);
    check("mm_res_max", 32'(res_max), 32'd9);
    $display("mm result: id=%0d data=%0d min=%0d max=%0d", res_id, res_data, res_min, res_max);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
